// File: rtl/z80_sys_top.sv
// Minimal Z80 single-board system: CPU core, reset stretch, clock enable, 8 KB boot ROM, 2 KB RAM, LED/button I/O.
// Optional define Z80_IO_TRACE_EN compiles a simulation trace of I/O writes and HALT entry.

module z80_core (
   input  logic        CLK_n,
   input  logic        RESET_n,
   input  logic        CEN,
   input  logic        WAIT_n,
   input  logic        INT_n,
   input  logic        NMI_n,
   input  logic        BUSRQ_n,
   output logic        M1_n,
   output logic        MREQ_n,
   output logic        IORQ_n,
   output logic        RD_n,
   output logic        WR_n,
   output logic        RFSH_n,
   output logic        HALT_n,
   output logic [15:0] A,
   input  logic [7:0]  DI,
   output logic [7:0]  DO
);
   typedef enum logic [2:0] {MC_FETCH, MC_RFSH, MC_OP1, MC_OP2, MC_EXEC, MC_HALT} mc_t;

   mc_t         mc_r, mc_n;
   logic        ph_r, ph_n;
   logic [15:0] pc_r, pc_n;
   logic [7:0]  acc_r, acc_n, ir_r, ir_n, lo_r, lo_n, hi_r, hi_n;
   logic [6:0]  r_r, r_n;
   logic        stall_s, is_rd_s;

   assign stall_s = (!WAIT_n && ph_r) || !BUSRQ_n;
   assign is_rd_s = (ir_r == 8'h3A) || (ir_r == 8'hDB);

   always_ff @(posedge CLK_n) begin
      if (!RESET_n) begin
         mc_r  <= MC_FETCH;
         ph_r  <= 1'b0;
         pc_r  <= 16'h0000;
         acc_r <= 8'hFF;
         ir_r  <= 8'h00;
         lo_r  <= 8'h00;
         hi_r  <= 8'h00;
         r_r   <= 7'd0;
      end else if (CEN && !stall_s) begin
         mc_r  <= mc_n;
         ph_r  <= ph_n;
         pc_r  <= pc_n;
         acc_r <= acc_n;
         ir_r  <= ir_n;
         lo_r  <= lo_n;
         hi_r  <= hi_n;
         r_r   <= r_n;
      end
   end

   // Every bus cycle except refresh spans two enable ticks; data is sampled at the end of the second.
   always_comb begin
      mc_n = mc_r;  ph_n = ph_r;  pc_n = pc_r;  acc_n = acc_r;
      ir_n = ir_r;  lo_n = lo_r;  hi_n = hi_r;  r_n = r_r;
      M1_n = 1'b1;  MREQ_n = 1'b1;  IORQ_n = 1'b1;  RD_n = 1'b1;
      WR_n = 1'b1;  RFSH_n = 1'b1;  HALT_n = 1'b1;
      A    = pc_r;  DO = acc_r;
      case (mc_r)
         MC_FETCH: begin
            M1_n = 1'b0;  MREQ_n = 1'b0;  RD_n = 1'b0;
            ph_n = ~ph_r;
            if (ph_r) begin
               ir_n = DI;
               pc_n = pc_r + 16'd1;
               mc_n = MC_RFSH;
            end else begin
               mc_n = MC_FETCH;
            end
         end
         MC_RFSH: begin
            RFSH_n = 1'b0;  MREQ_n = 1'b0;
            A    = {9'd0, r_r};
            r_n  = r_r + 7'd1;
            ph_n = 1'b0;
            case (ir_r)
               8'h3E, 8'hD3, 8'hDB, 8'h32, 8'h3A: mc_n = MC_OP1;
               8'h76:                             mc_n = MC_HALT;
               default:                           mc_n = MC_FETCH;
            endcase
         end
         MC_OP1, MC_OP2: begin
            MREQ_n = 1'b0;  RD_n = 1'b0;
            ph_n = ~ph_r;
            if (!ph_r) begin
               mc_n = mc_r;
            end else if (mc_r == MC_OP1) begin
               lo_n = DI;
               pc_n = pc_r + 16'd1;
               if (ir_r == 8'h3E) begin
                  acc_n = DI;
                  mc_n  = MC_FETCH;
               end else if ((ir_r == 8'h32) || (ir_r == 8'h3A)) begin
                  mc_n = MC_OP2;
               end else begin
                  mc_n = MC_EXEC;
               end
            end else begin
               hi_n = DI;
               pc_n = pc_r + 16'd1;
               mc_n = MC_EXEC;
            end
         end
         MC_EXEC: begin
            ph_n = ~ph_r;
            case (ir_r)
               8'h32: begin A = {hi_r, lo_r}; MREQ_n = 1'b0; WR_n = ~ph_r; end
               8'h3A: begin A = {hi_r, lo_r}; MREQ_n = 1'b0; RD_n = 1'b0; end
               8'hD3: begin A = {acc_r, lo_r}; IORQ_n = 1'b0; WR_n = ~ph_r; end
               8'hDB: begin A = {acc_r, lo_r}; IORQ_n = 1'b0; RD_n = 1'b0; end
               default: A = pc_r;
            endcase
            if (ph_r) begin
               acc_n = is_rd_s ? DI : acc_r;
               mc_n  = MC_FETCH;
            end else begin
               mc_n = MC_EXEC;
            end
         end
         MC_HALT: begin
            HALT_n = 1'b0;
            if (!INT_n || !NMI_n) begin
               mc_n = MC_FETCH;
            end else begin
               mc_n = MC_HALT;
            end
         end
         default: mc_n = MC_FETCH;
      endcase
   end
endmodule

module z80_sys_top #(
   parameter int    CLK_DIV     = 2,
   parameter int    RST_STRETCH = 16,
   parameter string ROM_FILE    = "rom.hex"
) (
   input logic       CLK50MHZ,
   input logic [1:0] BUTTON_N
);
   localparam int CNT_W = $clog2(RST_STRETCH + 1);

   logic             rst_meta_r, rst_sync_n, btn_meta_r, btn_sync_r;
   logic [CNT_W-1:0] stretch_r;
   logic             cpu_rst_n, cpu_cen;
   logic [3:0]       div_r;
   logic [7:0]       led_reg;
   logic [15:0]      cpu_addr;
   logic [7:0]       cpu_di, cpu_do, rom_q_r, ram_q_r;
   logic             cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_halt_n;
   logic             mem_cyc_s, io_cyc_s, io_wr_s, rom_hit_s, ram_hit_s, unused_s;
   logic [7:0]       rom_mem [0:8191];
   logic [7:0]       ram_mem [0:2047];

   always_ff @(posedge CLK50MHZ) begin
      rst_meta_r <= BUTTON_N[0];
      rst_sync_n <= rst_meta_r;
      btn_meta_r <= BUTTON_N[1];
      btn_sync_r <= btn_meta_r;
   end

   // cpu_rst_n is set on the edge where the counter reaches RST_STRETCH.
   always_ff @(posedge CLK50MHZ) begin
      if (!rst_sync_n) begin
         stretch_r <= '0;
         cpu_rst_n <= 1'b0;
      end else begin
         if (stretch_r != CNT_W'(RST_STRETCH)) stretch_r <= stretch_r + CNT_W'(1);
         cpu_rst_n <= cpu_rst_n || (stretch_r == CNT_W'(RST_STRETCH - 1));
      end
   end

   always_ff @(posedge CLK50MHZ) begin
      if (!rst_sync_n || !cpu_rst_n) begin
         div_r   <= 4'd0;
         cpu_cen <= 1'b0;
      end else if (div_r == 4'(CLK_DIV - 1)) begin
         div_r   <= 4'd0;
         cpu_cen <= 1'b1;
      end else begin
         div_r   <= div_r + 4'd1;
         cpu_cen <= 1'b0;
      end
   end

   z80_core cpu (
      .CLK_n(CLK50MHZ), .RESET_n(cpu_rst_n), .CEN(cpu_cen),
      .WAIT_n(1'b1), .INT_n(1'b1), .NMI_n(1'b1), .BUSRQ_n(1'b1),
      .M1_n(cpu_m1_n), .MREQ_n(cpu_mreq_n), .IORQ_n(cpu_iorq_n), .RD_n(cpu_rd_n),
      .WR_n(cpu_wr_n), .RFSH_n(cpu_rfsh_n), .HALT_n(cpu_halt_n),
      .A(cpu_addr), .DI(cpu_di), .DO(cpu_do)
   );

   assign mem_cyc_s = !cpu_mreq_n && cpu_rfsh_n;
   assign io_cyc_s  = !cpu_iorq_n && cpu_m1_n;
   assign io_wr_s   = cpu_cen && io_cyc_s && !cpu_wr_n;
   assign rom_hit_s = (cpu_addr[15:13] == 3'b000);
   assign ram_hit_s = (cpu_addr[15:11] == 5'b10000);
   assign unused_s  = &{1'b0, cpu_halt_n};

   // Registered ROM/RAM reads: the address is stable a full clock before the CPU samples DI.
   always_ff @(posedge CLK50MHZ) begin
      rom_q_r <= rom_mem[cpu_addr[12:0]];
      ram_q_r <= ram_mem[cpu_addr[10:0]];
      if (cpu_cen && mem_cyc_s && !cpu_wr_n && ram_hit_s) ram_mem[cpu_addr[10:0]] <= cpu_do;
   end

   always_ff @(posedge CLK50MHZ) begin
      if (!rst_sync_n) begin
         led_reg <= 8'h00;
      end else if (io_wr_s && (cpu_addr[7:0] == 8'h00)) begin
         led_reg <= cpu_do;
      end else begin
         led_reg <= led_reg;
      end
   end

   always_comb begin
      cpu_di = 8'hFF;
      if (!cpu_m1_n && !cpu_iorq_n) begin
         cpu_di = 8'hFF;
      end else if (io_cyc_s && !cpu_rd_n) begin
         case (cpu_addr[7:0])
            8'h00:   cpu_di = led_reg;
            8'h01:   cpu_di = {7'd0, ~btn_sync_r};
            default: cpu_di = 8'hFF;
         endcase
      end else if (mem_cyc_s && !cpu_rd_n) begin
         if (rom_hit_s) begin
            cpu_di = rom_q_r;
         end else if (ram_hit_s) begin
            cpu_di = ram_q_r;
         end else begin
            cpu_di = 8'hFF;
         end
      end else begin
         cpu_di = 8'hFF;
      end
   end

`ifdef Z80_IO_TRACE_EN
   logic halt_q_r;

   always_ff @(posedge CLK50MHZ) begin
      halt_q_r <= cpu_halt_n;
      if (io_wr_s) $display("IOWR %02h %02h", cpu_addr[7:0], cpu_do);
      if (halt_q_r && !cpu_halt_n) $display("HALT @%0t", $time);
   end
`else
   // No trace logic in this build.
`endif
endmodule

// File: tb/tb_z80_sys_top.sv
// Bench for z80_sys_top: directed reset/clock-enable timing plus randomized programs checked
// against an instruction-level model of the board (memory map, I/O map, LED register).

module tb_z80_sys_top;
   logic       clk = 1'b0;
   logic [1:0] button_n = 2'b10;
   int         total = 0;
   int         bad = 0;
   logic [7:0] prog[$];
   logic [7:0] m_rom [0:8191];
   logic [7:0] m_ram [0:2047];
   logic [7:0] m_led;

   always #10 clk = ~clk;

   z80_sys_top #(.CLK_DIV(2), .RST_STRETCH(16), .ROM_FILE("")) dut (
      .CLK50MHZ(clk),
      .BUTTON_N(button_n)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_rd(input logic [15:0] a);
      if (a < 16'h2000) return m_rom[a[12:0]];
      if (a >= 16'h8000 && a < 16'h8800) return m_ram[a - 16'h8000];
      return 8'hFF;
   endfunction

   // Executes the ROM image instruction by instruction until HALT.
   task automatic model_run(input logic btn1);
      logic [15:0] pc, ad;
      logic [7:0]  op, acc, n;
      bit          done;
      pc = 16'h0000; acc = 8'hFF; done = 0;
      for (int step = 0; step < 200 && !done; step++) begin
         op = m_rd(pc); pc++;
         case (op)
            8'h3E: begin acc = m_rd(pc); pc++; end
            8'hD3: begin n = m_rd(pc); pc++; if (n == 8'h00) m_led = acc; end
            8'hDB: begin
               n = m_rd(pc); pc++;
               acc = (n == 8'h00) ? m_led : (n == 8'h01) ? {7'd0, ~btn1} : 8'hFF;
            end
            8'h32: begin
               ad = {m_rd(pc + 16'd1), m_rd(pc)}; pc += 16'd2;
               if (ad >= 16'h8000 && ad < 16'h8800) m_ram[ad - 16'h8000] = acc;
            end
            8'h3A: begin ad = {m_rd(pc + 16'd1), m_rd(pc)}; pc += 16'd2; acc = m_rd(ad); end
            8'h76: done = 1;
            default: ;
         endcase
      end
   endtask

   task automatic apply_prog();
      logic [7:0] v;
      for (int i = 0; i < 8192; i++) begin
         v = (i < prog.size()) ? prog[i] : 8'h00;
         m_rom[i] = v;
         dut.rom_mem[i] = v;
      end
   endtask

   task automatic wait_rst(input string tag);
      int n = 0;
      while (dut.cpu_rst_n !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk({tag, "_rst"}, 16'(dut.cpu_rst_n), 16'h1);
   endtask

   task automatic wait_halt(input string tag);
      int n = 0;
      while (dut.cpu_halt_n !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
      chk({tag, "_halt"}, 16'(dut.cpu_halt_n), 16'h0);
      repeat (4) @(negedge clk);
   endtask

   task automatic run_prog(input string tag, input logic btn1);
      @(negedge clk);
      button_n = {btn1, 1'b0};
      repeat (4) @(negedge clk);
      apply_prog();
      m_led = 8'h00;
      model_run(btn1);
      button_n[0] = 1'b1;
      wait_rst(tag);
      wait_halt(tag);
      chk({tag, "_led"}, 16'(dut.led_reg), 16'(m_led));
   endtask

   initial begin
      int n;
      logic [7:0]  v, w, p;
      logic [15:0] ad;
      logic        b;

      // Directed: reset release timing and the LD/OUT/HALT program.
      prog = '{8'h3E, 8'h5A, 8'hD3, 8'h00, 8'h76};
      apply_prog();
      m_led = 8'h00;
      model_run(1'b1);
      repeat (3) @(negedge clk);
      chk("rst_cpu_rst_n", 16'(dut.cpu_rst_n), 16'h0);
      chk("rst_led", 16'(dut.led_reg), 16'h0);
      chk("rst_cen", 16'(dut.cpu_cen), 16'h0);
      repeat (3) @(negedge clk);
      button_n = 2'b11;
      n = 0;
      while (dut.rst_sync_n !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      chk("sync_rise", 16'(dut.rst_sync_n), 16'h1);
      n = 0;
      while (dut.cpu_rst_n !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("stretch_len", 16'(n), 16'd16);
      chk("first_fetch_m1", 16'(dut.cpu_m1_n), 16'h0);
      chk("first_fetch_addr", dut.cpu_addr, 16'h0000);
      n = 0;
      while (dut.cpu_cen !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      chk("cen_first", 16'(n), 16'd2);
      @(negedge clk);
      chk("cen_gap", 16'(dut.cpu_cen), 16'h0);
      @(negedge clk);
      chk("cen_second", 16'(dut.cpu_cen), 16'h1);
      wait_halt("dir");
      chk("dir_led", 16'(dut.led_reg), 16'(m_led));
      n = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (dut.cpu_halt_n !== 1'b0) n++; end
      chk("halt_stays", 16'(n), 16'd0);

      // Mid-run reset after HALT.
      button_n[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_led", 16'(dut.led_reg), 16'h0);
      chk("midrst_cpu_rst_n", 16'(dut.cpu_rst_n), 16'h0);
      repeat (47) @(negedge clk);
      button_n[0] = 1'b1;
      wait_rst("midrst");
      chk("midrst_addr", dut.cpu_addr, 16'h0000);
      wait_halt("midrst");
      chk("midrst_led_back", 16'(dut.led_reg), 16'h5A);

      // Randomized programs.
      for (int it = 0; it < 14; it++) begin
         v = 8'($urandom_range(1, 255));
         w = 8'($urandom_range(0, 255));
         b = 1'b1;
         case (it % 7)
            0: prog = '{8'h3E, v, 8'hD3, 8'h00, 8'h76};
            1, 2, 3: begin
               if (it == 1)       ad = 16'h8000;
               else if (it == 8)  ad = 16'h87FF;
               else if (it == 2)  ad = 16'h4000;
               else if (it == 9)  ad = 16'h8800;
               else               ad = 16'h1FFF;
               prog = '{8'h3E, v, 8'h32, ad[7:0], ad[15:8], 8'h3E, 8'h00,
                        8'h3A, ad[7:0], ad[15:8], 8'hD3, 8'h00, 8'h76};
            end
            4: begin
               b = (it == 4) ? 1'b0 : 1'b1;
               prog = '{8'hDB, 8'h01, 8'hD3, 8'h00, 8'h76};
            end
            5: begin
               p = 8'($urandom_range(1, 255));
               prog = '{8'h3E, v, 8'hD3, 8'h00, 8'h3E, w, 8'hD3, p,
                        8'h3E, 8'h00, 8'hDB, 8'h00, 8'hD3, 8'h00, 8'h76};
            end
            6: begin
               p = 8'($urandom_range(2, 255));
               prog = '{8'hDB, p, 8'hD3, 8'h00, 8'h76};
            end
            default: prog = '{8'h76};
         endcase
         run_prog($sformatf("t%0d", it), b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
